// File: rtl/tsn_buf_pkg.sv
// Shared buffer-manager constants and FSM state encodings for the TSN switch packet RAM.
package tsn_buf_pkg;

  localparam int ADDR_W     = 12;
  localparam int SLOT_SHIFT = 7;
  localparam int SLOT_CNT   = 32;
  localparam int SLOT_W     = ADDR_W - SLOT_SHIFT;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rd_state_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wr_state_e;

endpackage

// File: rtl/slot_fifo.sv
// Register FIFO of slot IDs; pop data is first-word fall-through.
// Push and pop may coincide; callers never push when full nor pop when empty.
module slot_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     pop_dat_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;

endmodule

// File: rtl/pkt_addr_mgmt.sv
// Slot address manager: allocates RAM slots to ingress packets, issues read bases in order, recycles on tail.
// Optional build macro PKT_ADDR_STAT_EN adds grant/drop/spurious-done counters.
module pkt_addr_mgmt #(
  parameter int ADDR_W     = tsn_buf_pkg::ADDR_W,
  parameter int SLOT_SHIFT = tsn_buf_pkg::SLOT_SHIFT,
  parameter int SLOT_CNT   = tsn_buf_pkg::SLOT_CNT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_pkt_req,
  output logic                          out_pkt_grant,
  output logic                          out_pkt_drop,
  output logic [ADDR_W-1:0]             addr2data_waddr,
  output logic                          addr2data_waddr_wr,
  output logic [ADDR_W-1:0]             addr2data_raddr,
  output logic                          addr2data_raddr_wr,
  input  logic                          in_tx_rdy,
  input  logic                          in_tx_done,
  output logic [$clog2(SLOT_CNT+1)-1:0] out_free_cnt,
  output logic                          out_init_done
`ifdef PKT_ADDR_STAT_EN
  ,
  output logic [31:0]                   out_grant_cnt,
  output logic [31:0]                   out_drop_cnt,
  output logic [15:0]                   out_err_cnt
`endif
);

  import tsn_buf_pkg::wr_state_e;
  import tsn_buf_pkg::rd_state_e;
  import tsn_buf_pkg::INIT;
  import tsn_buf_pkg::RUN;
  import tsn_buf_pkg::R_IDLE;
  import tsn_buf_pkg::R_BUSY;

  localparam int SID_W = ADDR_W - SLOT_SHIFT;
  localparam int CNT_W = $clog2(SLOT_CNT + 1);

  wr_state_e          wr_state_q, wr_state_d;
  rd_state_e          rd_state_q, rd_state_d;
  logic [SID_W-1:0]   init_cnt_q, init_cnt_d;
  logic [SID_W-1:0]   hold_q, hold_d;
  logic               grant_q, grant_d;
  logic               drop_q, drop_d;
  logic               waddr_wr_q, waddr_wr_d;
  logic               raddr_wr_q, raddr_wr_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;

  logic               init_push, rel_push, free_push, free_pop;
  logic [SID_W-1:0]   free_push_dat, free_head;
  logic               free_empty;
  logic [CNT_W-1:0]   free_cnt;
  logic               tx_push, tx_pop, tx_empty;
  logic [SID_W-1:0]   tx_head;
  logic [CNT_W-1:0]   tx_cnt_unused;

  // During INIT the read side is necessarily idle, so the two push sources never collide.
  assign free_push     = init_push | rel_push;
  assign free_push_dat = (wr_state_q == INIT) ? init_cnt_q : hold_q;

  slot_fifo #(.DEPTH(SLOT_CNT), .W(SID_W), .CNT_W(CNT_W)) u_free_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (free_push),
    .push_dat_i (free_push_dat),
    .pop_i      (free_pop),
    .pop_dat_o  (free_head),
    .empty_o    (free_empty),
    .count_o    (free_cnt)
  );

  slot_fifo #(.DEPTH(SLOT_CNT), .W(SID_W), .CNT_W(CNT_W)) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (tx_push),
    .push_dat_i (free_head),
    .pop_i      (tx_pop),
    .pop_dat_o  (tx_head),
    .empty_o    (tx_empty),
    .count_o    (tx_cnt_unused)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    init_cnt_d = init_cnt_q;
    init_push  = 1'b0;
    free_pop   = 1'b0;
    tx_push    = 1'b0;
    grant_d    = 1'b0;
    drop_d     = 1'b0;
    waddr_wr_d = 1'b0;
    waddr_d    = waddr_q;
    case (wr_state_q)
      INIT: begin
        init_push  = 1'b1;
        init_cnt_d = init_cnt_q + SID_W'(1);
        if (init_cnt_q == SID_W'(SLOT_CNT - 1)) wr_state_d = RUN;
        drop_d = in_pkt_req;
      end
      default: begin
        if (in_pkt_req) begin
          if (!free_empty) begin
            free_pop   = 1'b1;
            tx_push    = 1'b1;
            grant_d    = 1'b1;
            waddr_wr_d = 1'b1;
            waddr_d    = {free_head, {SLOT_SHIFT{1'b0}}};
          end else begin
            drop_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    hold_d     = hold_q;
    raddr_d    = raddr_q;
    raddr_wr_d = 1'b0;
    tx_pop     = 1'b0;
    rel_push   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (!tx_empty && in_tx_rdy) begin
          tx_pop     = 1'b1;
          hold_d     = tx_head;
          raddr_d    = {tx_head, {SLOT_SHIFT{1'b0}}};
          raddr_wr_d = 1'b1;
          rd_state_d = R_BUSY;
        end
      end
      default: begin
        if (in_tx_done) begin
          rel_push   = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= INIT;
      rd_state_q <= R_IDLE;
      init_cnt_q <= '0;
      hold_q     <= '0;
      grant_q    <= 1'b0;
      drop_q     <= 1'b0;
      waddr_wr_q <= 1'b0;
      raddr_wr_q <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      init_cnt_q <= init_cnt_d;
      hold_q     <= hold_d;
      grant_q    <= grant_d;
      drop_q     <= drop_d;
      waddr_wr_q <= waddr_wr_d;
      raddr_wr_q <= raddr_wr_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
    end
  end

  assign out_pkt_grant      = grant_q;
  assign out_pkt_drop       = drop_q;
  assign addr2data_waddr    = waddr_q;
  assign addr2data_waddr_wr = waddr_wr_q;
  assign addr2data_raddr    = raddr_q;
  assign addr2data_raddr_wr = raddr_wr_q;
  assign out_free_cnt       = free_cnt;
  assign out_init_done      = (wr_state_q == RUN);

`ifdef PKT_ADDR_STAT_EN
  logic [31:0] grant_cnt_q;
  logic [31:0] drop_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (grant_d) grant_cnt_q <= grant_cnt_q + 32'd1;
      if (drop_d)  drop_cnt_q  <= drop_cnt_q + 32'd1;
      if (in_tx_done && rd_state_q == R_IDLE) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign out_grant_cnt = grant_cnt_q;
  assign out_drop_cnt  = drop_cnt_q;
  assign out_err_cnt   = err_cnt_q;
`endif

endmodule
